// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state types and key indexing for the PS/2 key decoder.
// Pure declarations and combinational helpers; no latency and no flow control.
package ps2_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int NUM_KEYS  = 10;
  localparam int FRAME_BITS = 10;  // data[7:0], parity, stop (start bit is not stored)

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_CHECK
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  typedef enum logic [3:0] {
    K_UP    = 4'd0,
    K_DOWN  = 4'd1,
    K_LEFT  = 4'd2,
    K_RIGHT = 4'd3,
    K_SPACE = 4'd4,
    K_W     = 4'd5,
    K_S     = 4'd6,
    K_A     = 4'd7,
    K_D     = 4'd8,
    K_ENTER = 4'd9
  } key_idx_t;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  // One-hot mask of the key a scan code refers to; zero for unmapped codes.
  function automatic key_vec_t key_mask(input logic [7:0] code, input logic ext);
    key_vec_t m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    m[K_UP]    = 1'b1;
        SC_DOWN:  m[K_DOWN]  = 1'b1;
        SC_LEFT:  m[K_LEFT]  = 1'b1;
        SC_RIGHT: m[K_RIGHT] = 1'b1;
        SC_ENTER: m[K_ENTER] = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_SPACE: m[K_SPACE] = 1'b1;
        SC_W:     m[K_W]     = 1'b1;
        SC_S:     m[K_S]     = 1'b1;
        SC_A:     m[K_A]     = 1'b1;
        SC_D:     m[K_D]     = 1'b1;
        SC_ENTER: m[K_ENTER] = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

  // Odd parity over data+parity and a high stop bit.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (^f[8:0]) & f[9];
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 synchronizer, clock glitch filter and 11-bit frame receiver producing bytes.
// byte_valid/frame_err one cycle after the stop strobe (~FILTER_LEN+4 after raw edge); no backpressure.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic                  clk_s;
  logic                  data_s;
  logic [FW-1:0]         flt_cnt;
  logic                  filt;
  logic                  filt_d;
  logic                  strobe;
  logic [TW-1:0]         tmo_cnt;
  logic                  timeout;

  rx_state_t             state, state_nxt;
  logic [3:0]            bit_cnt, bit_cnt_nxt;
  logic [FRAME_BITS-1:0] frame, frame_nxt;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered level flips only after FILTER_LEN samples in a row disagree with it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      flt_cnt <= '0;
      filt    <= 1'b1;
      filt_d  <= 1'b1;
    end else begin
      filt_d <= filt;
      if (clk_s == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt    <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign strobe = filt_d & ~filt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tmo_cnt <= '0;
    end else if (strobe) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout = (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      frame   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      frame   <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    frame_nxt   = frame;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (strobe && !data_s) begin
          state_nxt   = RX_RECV;
          bit_cnt_nxt = '0;
        end
      end
      RX_RECV: begin
        if (strobe) begin
          frame_nxt[bit_cnt] = data_s;
          if (bit_cnt == 4'd9) begin
            state_nxt = RX_CHECK;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else if (timeout) begin
          frame_err = 1'b1;
          state_nxt = RX_IDLE;
        end
      end
      RX_CHECK: begin
        if (frame_ok(frame)) begin
          byte_valid = 1'b1;
        end else begin
          frame_err = 1'b1;
        end
        state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign code = frame[7:0];

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 make/break sequences into ten registered "key held" levels for two players.
// Keys update the cycle after byte_valid (~FILTER_LEN+5 cycles after the stop edge); no backpressure.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic space,
  output logic w,
  output logic s,
  output logic a,
  output logic d,
  output logic enter,
  output logic frame_err
);

  logic [7:0] code;
  logic       byte_valid;
  logic       rx_err;

  dec_state_t dec, dec_nxt;
  key_vec_t   keys, keys_nxt;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .byte_valid(byte_valid),
    .frame_err (rx_err)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dec  <= DEC_IDLE;
      keys <= '0;
    end else begin
      dec  <= dec_nxt;
      keys <= keys_nxt;
    end
  end

  // A corrupted frame may have swallowed a prefix byte, so restart prefix tracking but keep held keys.
  always_comb begin
    dec_nxt  = dec;
    keys_nxt = keys;
    if (rx_err) begin
      dec_nxt = DEC_IDLE;
    end else if (byte_valid) begin
      case (dec)
        DEC_IDLE: begin
          if (code == SC_E0) begin
            dec_nxt = DEC_EXT;
          end else if (code == SC_F0) begin
            dec_nxt = DEC_BRK;
          end else begin
            keys_nxt = keys | key_mask(code, 1'b0);
          end
        end
        DEC_EXT: begin
          if (code == SC_F0) begin
            dec_nxt = DEC_EXT_BRK;
          end else if (code != SC_E0) begin
            keys_nxt = keys | key_mask(code, 1'b1);
            dec_nxt  = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          keys_nxt = keys & ~key_mask(code, 1'b0);
          dec_nxt  = DEC_IDLE;
        end
        DEC_EXT_BRK: begin
          keys_nxt = keys & ~key_mask(code, 1'b1);
          dec_nxt  = DEC_IDLE;
        end
        default: dec_nxt = DEC_IDLE;
      endcase
    end
  end

  assign up        = keys[K_UP];
  assign down      = keys[K_DOWN];
  assign left      = keys[K_LEFT];
  assign right     = keys[K_RIGHT];
  assign space     = keys[K_SPACE];
  assign w         = keys[K_W];
  assign s         = keys[K_S];
  assign a         = keys[K_A];
  assign d         = keys[K_D];
  assign enter     = keys[K_ENTER];
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized + directed scoreboard bench for ps2_key_decoder with a scan-code-level reference model.
module tb_ps2_key_decoder;

  localparam int FLT = 8;
  localparam int TMO = 2000;
  localparam int HP  = 30;   // PS/2 half period in system cycles

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic up, down, left, right, space, w, s, a, d, enter, frame_err;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right), .space(space),
    .w(w), .s(s), .a(a), .d(d), .enter(enter), .frame_err(frame_err)
  );

  typedef struct {
    bit       err;
    bit [9:0] keys;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: bit order up,down,left,right,space,w,s,a,d,enter (bit 0 = up)
  bit [9:0] mkeys = '0;
  bit       m_ext = 1'b0;
  bit       m_brk = 1'b0;
  int       map_norm[bit [7:0]];
  int       map_ext[bit [7:0]];
  bit [7:0] pool[16] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h29, 8'h1D, 8'h1B, 8'h1C,
                         8'h23, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'hE1};

  function automatic bit [9:0] act_keys();
    return {enter, d, a, s, w, space, right, left, down, up};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit err);
    exp_t e;
    e.err  = err;
    e.keys = mkeys;
    exp_q.push_back(e);
  endtask

  task automatic model_frame(input bit [7:0] b, input bit bad);
    if (bad) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (!m_brk && b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (!m_brk && b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      int idx;
      idx = -1;
      if (m_ext && map_ext.exists(b)) idx = map_ext[b];
      else if (!m_ext && map_norm.exists(b)) idx = map_norm[b];
      if (idx >= 0) mkeys[idx] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    push_exp(bad);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HP) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HP) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad);
    logic [10:0] f;
    model_frame(b, bad);
    f = {1'b1, bad ? (^b) : ~(^b), b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (2 * HP) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every received frame or error is matched against the oldest expectation.
  initial begin
    exp_t e;
    bit   ev_err;
    forever begin
      @(negedge clk);
      if (clrn && (dut.byte_valid || frame_err)) begin
        ev_err = frame_err;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_event: err=%0b keys=%h with nothing expected at %0t",
                   ev_err, act_keys(), $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_err_flag", 32'(ev_err), 32'(e.err));
          check("keys_after_frame", 32'(act_keys()), 32'(e.keys));
          check("frame_err_width", 32'(frame_err), 32'(0));
        end
      end
    end
  end

  initial begin
    map_norm[8'h29] = 4; map_norm[8'h1D] = 5; map_norm[8'h1B] = 6;
    map_norm[8'h1C] = 7; map_norm[8'h23] = 8; map_norm[8'h5A] = 9;
    map_ext[8'h75] = 0;  map_ext[8'h72] = 1;  map_ext[8'h6B] = 2;
    map_ext[8'h74] = 3;  map_ext[8'h5A] = 9;

    repeat (4) @(negedge clk);
    check("reset_keys", 32'(act_keys()), 32'(0));
    check("reset_err", 32'(frame_err), 32'(0));
    @(posedge clk);
    clrn = 1'b1;
    repeat (20) @(posedge clk);

    // make and break
    send_frame(8'h29, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h29, 1'b0);
    wait_drain("drain_make_break");

    // extended arrow, extended break, plain 75
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'h75, 1'b0);
    wait_drain("drain_extended");

    // concurrency
    send_frame(8'h1D, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    wait_drain("drain_concurrency");

    // parity error then good frame
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0);
    wait_drain("drain_parity");

    // glitch on idle clock line
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_keys", 32'(act_keys()), 32'(mkeys));
    check("glitch_queue", exp_q.size(), 0);

    // timeout mid-frame, then a full frame
    m_ext = 1'b0;
    m_brk = 1'b0;
    push_exp(1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    repeat (TMO + 100) @(posedge clk);
    wait_drain("drain_timeout");
    send_frame(8'h23, 1'b0);
    wait_drain("drain_after_timeout");

    // asynchronous reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    #2;
    clrn = 1'b0;
    #2;
    check("async_reset_keys", 32'(act_keys()), 32'(0));
    check("async_reset_err", 32'(frame_err), 32'(0));
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    mkeys = '0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (5) @(posedge clk);
    clrn = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    wait_drain("drain_after_reset");

    // randomized scan-code stream with occasional parity errors
    for (int n = 0; n < 30; n++) begin
      bit [7:0] b;
      if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 15)];
      send_frame(b, $urandom_range(0, 7) == 0);
    end
    wait_drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
